// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding and
// the parameter sanity check used at elaboration.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // True when a W-bit word splits into whole C-bit chunks.
    function automatic bit chunking_ok(input int w, input int c);
        return (c >= 1) && (c <= w) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One C-bit slice of the add/sub datapath. B is inverted in subtract mode.
// The carry into the slice MSB is recovered from the MSB sum bit, which lets
// the last stage form signed overflow without a second adder.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int C = 8
)(
    input  logic [C-1:0] i_a,
    input  logic [C-1:0] i_b,
    input  logic         i_cin,
    input  logic         i_mode,
    output logic [C-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    logic [C-1:0] w_b;
    logic [C:0]   w_full;

    assign w_b    = (i_mode == MODE_SUB) ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{C{1'b0}}, i_cin};
    assign o_sum  = w_full[C-1:0];
    assign o_cout = w_full[C];
    // sum = a ^ b ^ carry_in at every bit, so the MSB carry-in falls out here.
    assign o_cmsb = w_full[C-1] ^ i_a[C-1] ^ w_b[C-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined W-bit adder/subtractor. Stage k adds chunk k using the carry
// registered by stage k-1, so the critical path is one C-bit add regardless
// of W. Operand chunks not yet consumed travel in skew registers; finished
// result chunks travel in deskew registers. Storage is packed into flat
// vectors holding exactly the chunks each stage needs:
//   result chunks of stage k : r_res chunks [res_off(k) +: k+1]
//   operand chunks of stage k: r_ska/r_skb chunks [skew_off(k) +: S-1-k],
//                              local index j holds operand chunk k+1+j.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int W = 32,
    parameter int C = 8
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         ovf,
    output logic         zero
);

    localparam int S     = W / C;
    localparam int NRES  = (S * (S + 1)) / 2;
    localparam int NSKEW = (S > 1) ? (S * (S - 1)) / 2 : 1;

    function automatic int res_off(input int k);
        return (k * (k + 1)) / 2;
    endfunction

    function automatic int skew_off(input int k);
        return k * (S - 1) - (k * (k - 1)) / 2;
    endfunction

    if (!chunking_ok(W, C)) begin : g_param_check
        $error("pipe_addsub: W must be a positive multiple of C");
    end

    logic [S-1:0]       r_v;
    logic [S-1:0]       r_carry;
    logic [S-1:0]       r_mode;
    logic [NRES*C-1:0]  r_res;
    logic [NSKEW*C-1:0] r_ska;
    logic [NSKEW*C-1:0] r_skb;
    logic               r_ovf;
    logic               r_zero;

    logic [C-1:0] w_a_ch   [S];
    logic [C-1:0] w_b_ch   [S];
    logic [C-1:0] w_sum_ch [S];
    logic [S-1:0] w_cin;
    logic [S-1:0] w_mode;
    logic [S-1:0] w_cout;
    logic [S-1:0] w_cmsb;
    logic [S:0]   w_v_shift;
    logic [W-1:0] w_res_last;
    logic         w_advance;
    logic         w_unused;

    // Handshake: an operation enters on in_valid & in_ready and a result
    // leaves on out_valid & out_ready. The whole pipe moves as one unit
    // whenever the last stage is empty or being drained; otherwise every
    // stage (data, carries, valids) holds, which keeps the outputs stable
    // while a result waits. Empty stages are simply overwritten.
    assign w_advance = out_ready | ~r_v[S-1];
    assign in_ready  = w_advance;

    assign w_v_shift = {r_v, in_valid};

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_a_ch[k] = a[C-1:0];
            assign w_b_ch[k] = b[C-1:0];
            assign w_cin[k]  = cin;
            assign w_mode[k] = mode;
        end else begin : g_next
            assign w_a_ch[k] = r_ska[skew_off(k-1)*C +: C];
            assign w_b_ch[k] = r_skb[skew_off(k-1)*C +: C];
            assign w_cin[k]  = r_carry[k-1];
            assign w_mode[k] = r_mode[k-1];
        end

        addsub_chunk #(.C(C)) u_chunk (
            .i_a    (w_a_ch[k]),
            .i_b    (w_b_ch[k]),
            .i_cin  (w_cin[k]),
            .i_mode (w_mode[k]),
            .o_sum  (w_sum_ch[k]),
            .o_cout (w_cout[k]),
            .o_cmsb (w_cmsb[k])
        );
    end

    // Assemble the full result entering the output register, for the zero flag.
    always_comb begin
        w_res_last = '0;
        for (int j = 0; j < S - 1; j++) begin
            w_res_last[j*C +: C] = r_res[(res_off(S-2) + j)*C +: C];
        end
        w_res_last[(S-1)*C +: C] = w_sum_ch[S-1];
    end

    // Advance valids, carries, skew and deskew chunks, and the output flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_carry <= '0;
            r_mode  <= '0;
            r_res   <= '0;
            r_ska   <= '0;
            r_skb   <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_advance) begin
            r_v     <= w_v_shift[S-1:0];
            r_carry <= w_cout;
            r_mode  <= w_mode;
            for (int k = 0; k < S; k++) begin
                for (int j = 0; j < k; j++) begin
                    r_res[(res_off(k) + j)*C +: C] <= r_res[(res_off(k-1) + j)*C +: C];
                end
                r_res[(res_off(k) + k)*C +: C] <= w_sum_ch[k];
            end
            for (int j = 0; j < S - 1; j++) begin
                r_ska[j*C +: C] <= a[(j+1)*C +: C];
                r_skb[j*C +: C] <= b[(j+1)*C +: C];
            end
            for (int k = 1; k < S - 1; k++) begin
                for (int j = 0; j < S - 1 - k; j++) begin
                    r_ska[(skew_off(k) + j)*C +: C] <= r_ska[(skew_off(k-1) + j + 1)*C +: C];
                    r_skb[(skew_off(k) + j)*C +: C] <= r_skb[(skew_off(k-1) + j + 1)*C +: C];
                end
            end
            r_ovf  <= w_cmsb[S-1] ^ w_cout[S-1];
            r_zero <= (w_res_last == '0);
        end
    end

    assign out_valid = r_v[S-1];
    assign sum       = r_res[res_off(S-1)*C +: W];
    assign carry     = r_carry[S-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    // The last stage's mode, the inner stages' MSB carries and the shifted-out
    // valid have no consumer.
    assign w_unused = ^{r_mode[S-1], w_cmsb, w_v_shift[S]};

endmodule
